param_sp_ram: RTL

PARAM_SP_RAM -- requirements
Module: param_sp_ram

---
 rtl/param_sp_ram_pkg.sv | 13 +
 rtl/param_sp_ram_core.sv | 62 ++++++
 rtl/param_sp_ram.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/param_sp_ram_pkg.sv
// Shared types and default sizes for the param_sp_ram block.
package param_sp_ram_pkg;

    // Controller phases: CLEAR zeroes the array once after reset, RUN serves requests.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;

endpackage : param_sp_ram_pkg

// File: rtl/param_sp_ram_core.sv
// Byte-enabled single-port storage array with one write port and one
// registered read port. The read register holds its value between reads.
module param_sp_ram_core
    import param_sp_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W/8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;

    // Byte-lane writes into the array.
    // NOTE: the array has no reset; the controller's clear pass zeroes it,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (wr_en && wr_be[b]) begin
                mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Next read-register value: capture on a read, otherwise hold.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? mem_q[rd_addr] : rd_data_q;
    end

    // Read register with synchronous reset.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule : param_sp_ram_core

// File: rtl/param_sp_ram.sv
// Parameterised single-port RAM with byte enables and a post-reset clear
// pass. Holds the CLEAR/RUN controller, clear counter and request handshake;
// storage lives in param_sp_ram_core.
// Build option: define PARAM_SP_RAM_OUTREG_EN to add an output register
// stage (read latency 2 instead of 1).
module param_sp_ram
    import param_sp_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata
);

    localparam int BE_W = DATA_W/8;

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
        $error("param_sp_ram: DATA_W must be a non-zero multiple of 8");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic              accept;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [BE_W-1:0]   mem_wr_be;
    logic              mem_rd_en;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              out_rvalid;
    logic [DATA_W-1:0] out_rdata;

    // Next-state logic: walk the clear counter once, then stay in RUN.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // Controller registers; reset restarts the clear pass from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Handshake and array port steering: the clear pass owns the write port
    // in CLEAR, requests own it in RUN; reset blocks every access.
    always_comb begin
        ready       = (state_q == RUN) && !rst;
        accept      = req && ready;
        mem_wr_en   = 1'b0;
        mem_wr_addr = addr;
        mem_wr_data = wdata;
        mem_wr_be   = be;
        mem_rd_en   = accept && !we;
        if (state_q == CLEAR) begin
            mem_wr_en   = !rst;
            mem_wr_addr = clr_cnt_q;
            mem_wr_data = '0;
            mem_wr_be   = {BE_W{1'b1}};
        end else begin
            mem_wr_en   = accept && we;
        end
    end

    param_sp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (mem_wr_en),
        .wr_addr  (mem_wr_addr),
        .wr_data  (mem_wr_data),
        .wr_be    (mem_wr_be),
        .rd_en    (mem_rd_en),
        .rd_addr  (addr),
        .rd_valid (core_rvalid),
        .rd_data  (core_rdata)
    );

`ifdef PARAM_SP_RAM_OUTREG_EN
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;

    // Output stage input: valid and data move together.
    always_comb begin
        out_valid_d = core_rvalid;
        out_data_d  = core_rdata;
    end

    // Output register stage adding one cycle of read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_rvalid = out_valid_q;
    assign out_rdata  = out_data_q;
`else
    assign out_rvalid = core_rvalid;
    assign out_rdata  = core_rdata;
`endif

    // Outputs read as zero while reset is held, so a read accepted just
    // before reset never shows a pulse.
    always_comb begin
        rvalid = out_rvalid && !rst;
        rdata  = rst ? '0 : out_rdata;
    end

endmodule : param_sp_ram
